// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// default memory depth and the request legality check.
package lsu_pkg;

  localparam int unsigned DEPTH_WORDS_DEFAULT = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Unsigned widths only exist for loads.
  function automatic logic f3_invalid(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction (loads) and lane merge (sub-word stores)
// between a full memory word and the core's right-aligned data.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data_c,
  output logic [31:0] store_word_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c       = 8'(mem_word >> {addr_lo, 3'b000});
    half_c       = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    load_data_c  = mem_word;
    store_word_c = mem_word;

    case (funct3)
      F3_B:    load_data_c = {{24{byte_c[7]}}, byte_c};
      F3_BU:   load_data_c = {24'd0, byte_c};
      F3_H:    load_data_c = {{16{half_c[15]}}, half_c};
      F3_HU:   load_data_c = {16'd0, half_c};
      default: load_data_c = mem_word;
    endcase

    // Only the addressed lane changes; the rest keeps the word just read.
    case (funct3[1:0])
      2'b00:   store_word_c[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (addr_lo[1]) store_word_c[31:16] = wdata[15:0];
        else            store_word_c[15:0]  = wdata[15:0];
      end
      default: store_word_c = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store initiator for a word-addressed memory, with
// read-modify-write sub-word stores. Define LSU_MISALIGN_TRAP_EN to fault misaligned h/w accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, data_q;
  logic        accept_c, req_err_c, misalign_c, oob_c;
  logic [31:0] load_data_c, store_word_c;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  assign oob_c     = ({2'b00, req_addr[31:2]} >= DEPTH_WORDS);
  assign req_err_c = f3_invalid(req_we, req_funct3) || oob_c || misalign_c;
  assign accept_c  = req_valid && req_ready;
  assign mem_addr  = {addr_q[31:2], 2'b00};

  lsu_lane_align u_lane_align (
    .funct3      (f3_q),
    .addr_lo     (addr_q[1:0]),
    .mem_word    (mem_rdata),
    .wdata       (data_q),
    .load_data_c (load_data_c),
    .store_word_c(store_word_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (req_err_c)                           state_d = RESP;
          else if (req_we && req_funct3 == F3_W)   state_d = WR;
          else                                     state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // data_q holds store data at accept, then the extracted load or merged word after RD.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      f3_q   <= 3'd0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
    end else if (accept_c) begin
      we_q   <= req_we;
      err_q  <= req_err_c;
      f3_q   <= req_funct3;
      addr_q <= req_addr;
      data_q <= req_wdata;
    end else if (state_q == RD) begin
      data_q <= we_q ? store_word_c : load_data_c;
    end
  end

  always_comb begin
    req_ready    = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_wdata    = 32'd0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = 32'd0;
    case (state_q)
      IDLE: req_ready = !reset;
      RD:   mem_read_en = !reset;
      WR: begin
        mem_write_en = !reset;
        mem_wdata    = data_q;
      end
      default: begin
        resp_valid = !reset;
        resp_err   = err_q && !reset;
        resp_rdata = (we_q || err_q || reset) ? 32'd0 : data_q;
      end
    endcase
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store initiator between the core's memory stage and the word-addressed `data_memory`. It accepts one load or store per handshake and converts RV32I byte, halfword and word accesses into whole-word memory transactions. Loads get lane extraction and sign/zero extension. Sub-word stores use read-modify-write, because the memory only writes full words. It also checks bounds and alignment before touching memory, and reports each result with a one-cycle response pulse.

## Interface
Parameters:
- `DEPTH_WORDS`, default 16: number of 32-bit words in the attached memory; used for the bounds check.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: LSU can accept a request; equals `(state==IDLE) && !reset`.
- `req_we` in 1: 1 for store, 0 for load.
- `req_funct3` in 3: RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: access faulted; qualified by `resp_valid`.
- `mem_addr` out 32: word-aligned byte address, `{addr_q[31:2],2'b00}`.
- `mem_wdata` out 32: full word to write.
- `mem_read_en` out 1: read strobe. Memory read is combinational.
- `mem_write_en` out 1: write strobe. Memory write is synchronous.
- `mem_rdata` in 32: memory read data.

## Operation
- States: `IDLE`, `RD`, `WR`, `RESP`.
- **IDLE:** on `req_valid && req_ready`, latch `we`, `funct3`, `addr` and `wdata`, then check the request in this order:
  - invalid funct3 (011, 110, 111; or a store with funct3[2]=1), out of bounds (`addr[31:2] >= DEPTH_WORDS`), or misaligned when the trap is enabled: set `err_q` and go to `RESP`.
  - sw: go to `WR`.
  - any load, sb or sh: go to `RD`.
- **RD:**
  - `mem_read_en=1`; sample `mem_rdata` at the edge.
  - Load: register the extracted value, then go to `RESP`.
  - Store: register the merged word, then go to `WR`.
- **WR:** `mem_write_en=1`, `mem_wdata` = merged word (sw passes `wdata` through); then go to `RESP`.
- **RESP:** `resp_valid=1`, drive `resp_rdata` and `resp_err`; go to `IDLE`.
- Lane rules, little-endian:
  - Byte lane is `addr[1:0]`; halfword lane is `addr[1]`.
  - b/h sign-extend bit 7/15; bu/hu zero-extend.
  - sb/sh replace only the selected lane; the other bytes keep the values read.
- There is no response backpressure; the core stalls on `req_ready`.
- The memory strobes are never both high in one cycle.

## Timing
- Request accepted at edge T. Response pulse cycle:
  - Loads: T+2.
  - sw: T+2.
  - sb/sh: T+3.
  - Error: T+1.
- `req_ready` is low from the accept edge until the cycle after `RESP`, so back-to-back requests are accepted every 3 or 4 cycles.
- Reset values: state `IDLE`; `resp_valid`, `resp_err`, `resp_rdata`, `mem_*` all 0. `req_ready` is 0 while `reset` is high and 1 on the first cycle after.
- Reset mid-operation:
  - `mem_read_en` and `mem_write_en` are gated by `!reset`, so no write is issued.
  - An RMW aborted in `RD` or `WR` leaves memory unchanged.
  - No response is produced; the next state is `IDLE`.
- Erroring requests never assert `mem_read_en` or `mem_write_en`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: h/hu/sh with `addr[0]=1` and w/sw with `addr[1:0]!=0` produce an error response at T+1, with no memory access.
- Undefined:
  - Misalignment is ignored: h uses lane `addr[1]` and w ignores `addr[1:0]`.
  - The access proceeds normally.
  - Bounds and funct3 errors are still reported.

## Structure
- Package `lsu_pkg` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the state enum;
  - the `DEPTH_WORDS` default.
- Sub-module `lsu_lane_align`: combinational load extraction and store merge from (`funct3`, `addr[1:0]`, `mem_word`, `wdata`). It is instantiated once in `load_store_unit`.

## Test plan
- sw `0x11223344` to `0x8` → `WR` at T+1 with `mem_addr=0x8`, `mem_wdata=0x11223344`; `resp_valid` at T+2, `resp_err=0`; `mem_read_en` never high.
- Word at `0x8`=`0x11223344`; sb `0xAB` to `0x9` → `RD` at T+1, `WR` at T+2 with `mem_wdata=0x1122AB44`, response at T+3.
- Then lb `0x9` → `resp_rdata=0xFFFFFFAB` at T+2; lbu `0x9` → `0x000000AB`.
- Word at `0xC`=`0x8001_0000`; lh `0xE` → `0xFFFF8001`; lhu `0xE` → `0x00008001`.
- lw `0x40` with `DEPTH_WORDS=16` → `resp_err=1` at T+1, `resp_rdata=0`, no memory strobes. funct3=011 → same result.
- lw `0x6`: with the macro, error at T+1; without it, reads word `0x4` at T+2. Assert `reset` during `RD` of an sb → no `mem_write_en`, memory unchanged, `req_ready=1` the cycle after reset drops.
